// File: rtl/sprite_pkg.sv
// Sprite animation shared types and constants.
// Optional feature macro used by this slice: SPRITE_MIRROR_EN (horizontal mirroring).
package sprite_pkg;

    // Walk animation states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_A = 2'd1,
        WALK_B = 2'd2
    } anim_state_t;

    // Default sprite geometry (width = ROM word width, height = ROM depth)
    localparam int SPR_W_DEF = 32;
    localparam int SPR_H_DEF = 16;

    // Sprite ROM indices
    localparam logic [1:0] ROM_PROJ0  = 2'd0;
    localparam logic [1:0] ROM_PROJ1  = 2'd1;
    localparam logic [1:0] ROM_WALK_A = 2'd2;
    localparam logic [1:0] ROM_WALK_B = 2'd3;

    // Screen coordinate
    typedef logic [9:0] coord_t;

    // ROM that goes with each animation state; IDLE shows the standing frame
    function automatic logic [1:0] rom_sel_of(input anim_state_t s);
        logic [1:0] sel;
        case (s)
            WALK_B:  sel = ROM_WALK_B;
            IDLE:    sel = ROM_WALK_A;
            WALK_A:  sel = ROM_WALK_A;
            default: sel = ROM_WALK_A;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/anim_seq.sv
// Walk-cycle sequencer: IDLE/WALK_A/WALK_B FSM plus frame_tick divider.
// All transitions happen only on frame_tick so the frame never tears.
module anim_seq
    import sprite_pkg::*;
#(
    parameter int FRAME_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       moving,
    output logic [1:0] rom_sel
);

    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    anim_state_t state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [1:0]  rom_sel_r;

    // Next-state and next-count; nothing moves without frame_tick
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (frame_tick) begin
            case (state_r)
                IDLE: begin
                    cnt_s = 8'd0;
                    if (moving) begin
                        state_s = WALK_A;
                    end else begin
                        state_s = IDLE;
                    end
                end
                WALK_A, WALK_B: begin
                    if (!moving) begin
                        state_s = IDLE;
                        cnt_s   = 8'd0;
                    end else if (cnt_r == DIV_LAST) begin
                        state_s = (state_r == WALK_A) ? WALK_B : WALK_A;
                        cnt_s   = 8'd0;
                    end else begin
                        cnt_s   = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                end
            endcase
        end else begin
            state_s = state_r;
            cnt_s   = cnt_r;
        end
    end

    // State, counter and registered ROM select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            rom_sel_r <= ROM_WALK_A;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rom_sel_r <= rom_sel_of(state_s);
        end
    end

    assign rom_sel = rom_sel_r;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller: position latching on frame_tick and a
// two-stage pixel pipeline (hit test + ROM address, then ROM bit select).
// Optional macro SPRITE_MIRROR_EN adds face_left for horizontal mirroring.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int FRAME_DIV = 8,
    parameter int SPR_W     = SPR_W_DEF,
    parameter int SPR_H     = SPR_H_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_tick,
    input  logic                     moving,
`ifdef SPRITE_MIRROR_EN
    input  logic                     face_left,
`endif
    input  logic [9:0]               spr_x,
    input  logic [9:0]               spr_y,
    input  logic [9:0]               pix_x,
    input  logic [9:0]               pix_y,
    input  logic                     pix_valid,
    output logic [1:0]               rom_sel,
    output logic [$clog2(SPR_H)-1:0] rom_addr,
    input  logic [SPR_W-1:0]         rom_data,
    output logic                     pix_on,
    output logic                     pix_on_valid
);

    localparam int     CW    = $clog2(SPR_W);
    localparam int     AW    = $clog2(SPR_H);
    localparam coord_t W_LIM = coord_t'(SPR_W);
    localparam coord_t H_LIM = coord_t'(SPR_H);

    coord_t        sx_l, sy_l;
    coord_t        dx_s, dy_s;
    logic          v1, hit1;
    logic [CW-1:0] col1;
    logic [AW-1:0] rom_addr_r;
    logic [CW-1:0] bit_idx_s;
    logic          pix_on_r, pix_on_valid_r;
    logic          face_l;

    anim_seq #(.FRAME_DIV(FRAME_DIV)) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .moving     (moving),
        .rom_sel    (rom_sel)
    );

    // Latch position (and facing) once per frame; rendering sees only these
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_l   <= 10'd0;
            sy_l   <= 10'd0;
            face_l <= 1'b0;
        end else if (frame_tick) begin
            sx_l   <= spr_x;
            sy_l   <= spr_y;
`ifdef SPRITE_MIRROR_EN
            face_l <= face_left;
`else
            face_l <= 1'b0;
`endif
        end
    end

    // Offsets wrap mod 1024 so pixels left of/above the sprite fall out of range
    always_comb begin
        dx_s = pix_x - sx_l;
        dy_s = pix_y - sy_l;
    end

    // Stage 1: hit test and ROM row address; address holds on idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            hit1       <= 1'b0;
            rom_addr_r <= '0;
            col1       <= '0;
        end else if (pix_valid) begin
            v1         <= 1'b1;
            hit1       <= (dx_s < W_LIM) && (dy_s < H_LIM);
            rom_addr_r <= dy_s[AW-1:0];
            col1       <= dx_s[CW-1:0];
        end else begin
            v1         <= 1'b0;
            hit1       <= 1'b0;
        end
    end

    // ROM bit for this column; MSB is column 0 unless the sprite is mirrored
    always_comb begin
        if (face_l) begin
            bit_idx_s = col1;
        end else begin
            bit_idx_s = CW'(SPR_W - 1) - col1;
        end
    end

    // Stage 2: pixel output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_on_r       <= 1'b0;
            pix_on_valid_r <= 1'b0;
        end else begin
            pix_on_r       <= v1 && hit1 && rom_data[bit_idx_s];
            pix_on_valid_r <= v1;
        end
    end

    assign rom_addr     = rom_addr_r;
    assign pix_on       = pix_on_r;
    assign pix_on_valid = pix_on_valid_r;

endmodule

// File: doc/sprite_anim_ctrl.md
SPRITE_ANIM_CTRL -- requirements
Module: sprite_anim_ctrl

Interface
REQ-001 Parameter FRAME_DIV, default 8: frame_tick pulses per animation step, legal range 1..255.
REQ-002 Parameter SPR_W, default 32: sprite width in pixels, equal to the ROM word width.
REQ-003 Parameter SPR_H, default 16: sprite height in rows, equal to the ROM depth.
REQ-004 clk  in  1  single pixel clock; all state is clocked on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-007 moving  in  1  player walking request, level-sensitive.
REQ-008 spr_x / spr_y  in  10 / 10  sprite top-left corner in screen pixels.
REQ-009 pix_x / pix_y  in  10 / 10  current scan pixel.
REQ-010 pix_valid  in  1  pix_x/pix_y qualify this cycle (active video).
REQ-011 rom_sel  out  2  sprite ROM select: 0/1 = projectile frames, 2 = walk A/stand, 3 = walk B.
REQ-012 rom_addr  out  4  row address to the selected ROM.
REQ-013 rom_data  in  32  combinational row data from the selected ROM; bit 31 = column 0.
REQ-014 pix_on  out  1  sprite pixel lit.
REQ-015 pix_on_valid  out  1  pix_on qualifies the pixel presented two cycles earlier.

Function
REQ-016 Animation FSM states SHALL be IDLE, WALK_A and WALK_B; rom_sel = 2 in IDLE and WALK_A, and 3 in WALK_B.
REQ-017 An 8-bit tick counter SHALL count frame_tick pulses while in WALK_A or WALK_B.
REQ-018 On the frame_tick that brings the count to FRAME_DIV, the FSM SHALL toggle WALK_A<->WALK_B and the counter SHALL clear.
REQ-019 IDLE->WALK_A SHALL occur only on frame_tick with moving=1.
REQ-020 Any WALK state->IDLE SHALL occur only on frame_tick with moving=0, and the counter SHALL clear.
REQ-021 FSM state and rom_sel SHALL never change outside a frame_tick cycle, so the frame does not tear mid-frame.
REQ-022 spr_x/spr_y SHALL be latched into sx_l/sy_l only on frame_tick; rendering SHALL use only the latched values.
REQ-023 Stage 1, on pix_valid: dx = pix_x - sx_l and dy = pix_y - sy_l, both mod 2^10.
REQ-024 Stage 1: hit1 = (dx < SPR_W) && (dy < SPR_H); rom_addr <= dy[3:0]; col1 <= dx[4:0]; v1 <= pix_valid.
REQ-025 Stage 2: pix_on <= v1 && hit1 && rom_data[31-col1]; pix_on_valid <= v1.
REQ-026 Latency from pix_valid to pix_on_valid SHALL be exactly 2 cycles, with one result per cycle and no stalls.
REQ-027 Pixels left of or above the sprite SHALL produce hit1=0 through modulo wrap of dx/dy.
REQ-028 Sprites extending past the right or bottom screen edge SHALL be clipped by the scan range, with no wrap to column or row 0.
REQ-029 When pix_valid=0, stage 1 SHALL clear v1 and hit1, and rom_addr SHALL hold its value.
REQ-030 When frame_tick and pix_valid coincide, the pixel SHALL use the pre-update sx_l/sy_l.

Reset
REQ-031 Asserting rst_n low SHALL force state=IDLE, counter=0, sx_l=sy_l=0, rom_sel=2, rom_addr=0, v1=hit1=0, pix_on=0 and pix_on_valid=0, independent of clk.
REQ-032 Reset mid-animation or mid-line SHALL discard all in-flight pixels; the first valid output SHALL come 2 cycles after the first post-reset pix_valid.

Configuration
REQ-033 With SPRITE_MIRROR_EN defined, an input face_left (1 bit) SHALL exist; it is latched on frame_tick, and stage 2 SHALL use rom_data[col1] when the latched value is 1.
REQ-034 Without SPRITE_MIRROR_EN, face_left SHALL be absent and stage 2 SHALL always use rom_data[31-col1].

Structure
REQ-035 Package sprite_pkg SHALL hold anim_state_t, SPR_W/SPR_H defaults, the ROM index constants (ROM_PROJ0=0, ROM_PROJ1=1, ROM_WALK_A=2, ROM_WALK_B=3) and the 10-bit coordinate typedef.
REQ-036 Sub-module anim_seq SHALL contain the FSM and tick counter and output rom_sel; the top level SHALL contain position latching and the pixel pipeline.

Verification
REQ-037 Reset, then moving=1 and 1 frame_tick, SHALL give rom_sel=2 (WALK_A); 8 more ticks SHALL give rom_sel=3; 8 more ticks SHALL give rom_sel=2.
REQ-038 In WALK_B, moving=0 plus frame_tick SHALL give IDLE and rom_sel=2 on the next cycle, with the counter at 0.
REQ-039 Sprite at (100,50) with rom_data row 4 = 0x003FF000: pix (110,54) SHALL give pix_on=1 two cycles later; pix (109,54) SHALL give 0; pix (99,54) SHALL give 0 (wrap case).
REQ-040 A spr_x change mid-line without frame_tick SHALL not affect output; after frame_tick the new position SHALL take effect.
REQ-041 rst_n low for 1 cycle mid-line SHALL drive pix_on_valid and pix_on to 0 immediately; outputs SHALL resume 2 cycles after the next pix_valid.
REQ-042 With SPRITE_MIRROR_EN defined and face_left=1 latched, dx=0 SHALL sample rom_data bit 0.
